// File: rtl/fetch_pc_ctrl_if.sv
// fetch_pc_ctrl_if: instruction-bus and fetch-to-decode handshake bundle for fetch_pc_ctrl.
//
// Signals:
//   ireq_valid / ireq_addr   request to the instruction bus (fetch drives)
//   ireq_addr_ok             bus accepted the address
//   iresp_data_ok / iresp_data   in-order response with the fetched word
//   f_valid / f_pc / f_instr     instruction handed to decode (fetch drives)
//   f_ready                  decode accepts the instruction
//   f_adel                   address-error flag, present only with FETCH_ADEL_CHECK_EN
//
// Modports: master = fetch controller side, slave = bus/decode side.
interface fetch_pc_ctrl_if;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        ireq_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        f_valid;
    logic [31:0] f_pc;
    logic [31:0] f_instr;
    logic        f_ready;
`ifdef FETCH_ADEL_CHECK_EN
    logic        f_adel;
`endif

    modport master (
        output ireq_valid, ireq_addr, f_valid, f_pc, f_instr,
`ifdef FETCH_ADEL_CHECK_EN
        output f_adel,
`endif
        input  ireq_addr_ok, iresp_data_ok, iresp_data, f_ready
    );

    modport slave (
        input  ireq_valid, ireq_addr, f_valid, f_pc, f_instr,
`ifdef FETCH_ADEL_CHECK_EN
        input  f_adel,
`endif
        output ireq_addr_ok, iresp_data_ok, iresp_data, f_ready
    );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: fetch-stage sequencer owning the fetch PC.
//
// Issues one instruction-bus request at a time from pc_q, resolves redirects by fixed priority
// (eret > exc > branch > refetch > dec_redirect), counts responses made stale by redirects so
// they can be discarded, and hands one instruction at a time to decode via f_valid/f_ready.
//
// Ports:
//   clk, resetn                    clock, synchronous active-low reset
//   eret_valid/epc                 exception return and its target
//   exc_valid/exc_entrance         exception taken and its vector
//   branch_valid/branch_target     execute-stage mispredict redirect
//   refetch_valid/refetch_pc       decode refetch request
//   dec_redirect_valid/_pc         decode-stage taken correction
//   pred_taken/pred_pc             prediction for the pc whose response is returning
//   bus (fetch_pc_ctrl_if.master)  instruction bus and decode handshake
//
// Optional feature macro: FETCH_ADEL_CHECK_EN -- a misaligned pc_q in REQ issues no request and
// instead delivers f_instr=0 with f_adel=1 to decode.
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
    parameter int unsigned DROP_MAX = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            eret_valid,
    input  logic [31:0]     epc,
    input  logic            exc_valid,
    input  logic [31:0]     exc_entrance,
    input  logic            branch_valid,
    input  logic [31:0]     branch_target,
    input  logic            refetch_valid,
    input  logic [31:0]     refetch_pc,
    input  logic            dec_redirect_valid,
    input  logic [31:0]     dec_redirect_pc,
    input  logic            pred_taken,
    input  logic [31:0]     pred_pc,
    fetch_pc_ctrl_if.master bus
);
    localparam int unsigned DropW = $clog2(DROP_MAX + 1);
    localparam logic [DropW-1:0] DropMax = DropW'(DROP_MAX);

    typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             pend_valid_q, pend_valid_d;
    logic [31:0]      pend_pc_q, pend_pc_d;
    logic [2:0]       pend_rank_q, pend_rank_d;
    logic [DropW-1:0] drop_cnt_q, drop_cnt_d;
    logic             f_valid_q, f_valid_d;
    logic [31:0]      f_pc_q, f_pc_d;
    logic [31:0]      f_instr_q, f_instr_d;
`ifdef FETCH_ADEL_CHECK_EN
    logic             f_adel_q, f_adel_d;
`endif

    // Redirect resolution; a larger rank is more urgent, 0 means no redirect.
    logic [2:0]  redir_rank;
    logic [31:0] redir_pc;
    logic        redir;

    always_comb begin
        redir_rank = 3'd0;
        redir_pc   = '0;
        if (eret_valid) begin
            redir_rank = 3'd5;
            redir_pc   = epc;
        end else if (exc_valid) begin
            redir_rank = 3'd4;
            redir_pc   = exc_entrance;
        end else if (branch_valid) begin
            redir_rank = 3'd3;
            redir_pc   = branch_target;
        end else if (refetch_valid) begin
            redir_rank = 3'd2;
            redir_pc   = refetch_pc;
        end else if (dec_redirect_valid) begin
            redir_rank = 3'd1;
            redir_pc   = dec_redirect_pc;
        end
    end

    assign redir = (redir_rank != 3'd0);

    // A same-cycle redirect replaces the pending one only if at least as urgent.
    logic        take_new;
    logic [31:0] req_tgt;
    logic        adel_hit;
    logic        req_valid;
    logic        accept;
    logic        stale;
    logic        drop_inc;

    assign take_new = redir && (!pend_valid_q || (redir_rank >= pend_rank_q));
    assign req_tgt  = take_new ? redir_pc : pend_pc_q;

`ifdef FETCH_ADEL_CHECK_EN
    assign adel_hit = (state_q == StReq) && (pc_q[1:0] != 2'b00);
`else
    assign adel_hit = 1'b0;
`endif

    // No new request once the stale-response counter is saturated.
    assign req_valid = (state_q == StReq) && (drop_cnt_q != DropMax) && !adel_hit;
    assign accept    = req_valid && bus.ireq_addr_ok;
    assign stale     = bus.iresp_data_ok && (drop_cnt_q != '0);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        pend_rank_d  = pend_rank_q;
        f_valid_d    = f_valid_q;
        f_pc_d       = f_pc_q;
        f_instr_d    = f_instr_q;
`ifdef FETCH_ADEL_CHECK_EN
        f_adel_d     = f_adel_q;
`endif
        drop_inc     = 1'b0;

        unique case (state_q)
            StReq: begin
                if (adel_hit) begin
                    if (redir || pend_valid_q) begin
                        pc_d         = req_tgt;
                        pend_valid_d = 1'b0;
                    end else begin
                        f_valid_d = 1'b1;
                        f_pc_d    = pc_q;
                        f_instr_d = '0;
`ifdef FETCH_ADEL_CHECK_EN
                        f_adel_d  = 1'b1;
`endif
                        state_d   = StHold;
                    end
                end else if (accept) begin
                    if (redir || pend_valid_q) begin
                        // The just-accepted request is already wrong-path.
                        drop_inc     = 1'b1;
                        pc_d         = req_tgt;
                        pend_valid_d = 1'b0;
                    end else begin
                        state_d = StWait;
                    end
                end else if (take_new) begin
                    // Address must stay stable until accepted, so park the redirect.
                    pend_valid_d = 1'b1;
                    pend_pc_d    = redir_pc;
                    pend_rank_d  = redir_rank;
                end
            end
            StWait: begin
                if (redir) begin
                    // A live response arriving now is simply discarded; otherwise it is owed.
                    drop_inc = !(bus.iresp_data_ok && (drop_cnt_q == '0));
                    pc_d     = redir_pc;
                    state_d  = StReq;
                end else if (bus.iresp_data_ok && (drop_cnt_q == '0)) begin
                    f_valid_d = 1'b1;
                    f_pc_d    = pc_q;
                    f_instr_d = bus.iresp_data;
`ifdef FETCH_ADEL_CHECK_EN
                    f_adel_d  = 1'b0;
`endif
                    pc_d      = pred_taken ? pred_pc : pc_q + 32'd4;
                    state_d   = StHold;
                end
            end
            StHold: begin
                if (redir) begin
                    f_valid_d = 1'b0;
                    pc_d      = redir_pc;
                    state_d   = StReq;
                end else if (bus.f_ready) begin
                    f_valid_d = 1'b0;
                    state_d   = StReq;
                end
            end
            default: state_d = StReq;
        endcase

        drop_cnt_d = drop_cnt_q + DropW'(drop_inc) - DropW'(stale);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= StReq;
            pc_q         <= RESET_PC;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= '0;
            pend_rank_q  <= 3'd0;
            drop_cnt_q   <= '0;
            f_valid_q    <= 1'b0;
            f_pc_q       <= '0;
            f_instr_q    <= '0;
`ifdef FETCH_ADEL_CHECK_EN
            f_adel_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
            pend_rank_q  <= pend_rank_d;
            drop_cnt_q   <= drop_cnt_d;
            f_valid_q    <= f_valid_d;
            f_pc_q       <= f_pc_d;
            f_instr_q    <= f_instr_d;
`ifdef FETCH_ADEL_CHECK_EN
            f_adel_q     <= f_adel_d;
`endif
        end
    end

    assign bus.ireq_valid = req_valid;
    assign bus.ireq_addr  = pc_q;
    assign bus.f_valid    = f_valid_q;
    assign bus.f_pc       = f_pc_q;
    assign bus.f_instr    = f_instr_q;
`ifdef FETCH_ADEL_CHECK_EN
    assign bus.f_adel     = f_adel_q;
`endif
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb_fetch_pc_ctrl: directed scenarios plus a randomized run against a queue-based model of
// outstanding bus transactions for fetch_pc_ctrl.
module tb_fetch_pc_ctrl;
    localparam logic [31:0] ResetPc = 32'hbfc0_0000;
    localparam int          DropMax = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic        live;
    } ent_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        eret_valid, exc_valid, branch_valid, refetch_valid, dec_redirect_valid;
    logic [31:0] epc, exc_entrance, branch_target, refetch_pc, dec_redirect_pc;
    logic        pred_taken;
    logic [31:0] pred_pc;
    int          checks = 0;
    int          errors = 0;

    fetch_pc_ctrl_if bus ();

    fetch_pc_ctrl #(
        .RESET_PC (ResetPc),
        .DROP_MAX (DropMax)
    ) dut (
        .clk                (clk),
        .resetn             (resetn),
        .eret_valid         (eret_valid),
        .epc                (epc),
        .exc_valid          (exc_valid),
        .exc_entrance       (exc_entrance),
        .branch_valid       (branch_valid),
        .branch_target      (branch_target),
        .refetch_valid      (refetch_valid),
        .refetch_pc         (refetch_pc),
        .dec_redirect_valid (dec_redirect_valid),
        .dec_redirect_pc    (dec_redirect_pc),
        .pred_taken         (pred_taken),
        .pred_pc            (pred_pc),
        .bus                (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9e37_79b1) ^ 32'h5a5a_a5a5;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        eret_valid = 0; exc_valid = 0; branch_valid = 0; refetch_valid = 0;
        dec_redirect_valid = 0; pred_taken = 0;
        epc = '0; exc_entrance = '0; branch_target = '0; refetch_pc = '0;
        dec_redirect_pc = '0; pred_pc = '0;
        bus.ireq_addr_ok = 0; bus.iresp_data_ok = 0; bus.iresp_data = '0; bus.f_ready = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        resetn = 0;
        step();
        step();
        checks++;
        if (bus.ireq_valid !== 1'b1) begin
            errors++; $display("FAIL reset_ireq_valid got %b want 1", bus.ireq_valid);
        end
        checks++;
        if (bus.ireq_addr !== ResetPc) begin
            errors++; $display("FAIL reset_ireq_addr got %h want %h", bus.ireq_addr, ResetPc);
        end
        checks++;
        if (bus.f_valid !== 1'b0 || bus.f_pc !== 32'h0 || bus.f_instr !== 32'h0) begin
            errors++;
            $display("FAIL reset_f got v=%b pc=%h ins=%h want 0/0/0",
                     bus.f_valid, bus.f_pc, bus.f_instr);
        end
        resetn = 1;
    endtask

    task automatic test_basic_fetch();
        bus.ireq_addr_ok = 1;
        step();
        clear_inputs();
        checks++;
        if (bus.ireq_valid !== 1'b0) begin
            errors++; $display("FAIL basic_wait_ireq got %b want 0", bus.ireq_valid);
        end
        bus.iresp_data_ok = 1; bus.iresp_data = 32'h2402_0001; bus.f_ready = 1;
        step();
        bus.iresp_data_ok = 0;
        checks++;
        if (bus.f_valid !== 1'b1 || bus.f_pc !== 32'hbfc0_0000 || bus.f_instr !== 32'h2402_0001)
        begin
            errors++;
            $display("FAIL basic_deliver got v=%b pc=%h ins=%h want 1/bfc00000/24020001",
                     bus.f_valid, bus.f_pc, bus.f_instr);
        end
        step();
        clear_inputs();
        checks++;
        if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 32'hbfc0_0004 || bus.f_valid !== 1'b0)
        begin
            errors++;
            $display("FAIL basic_next_req got v=%b a=%h fv=%b want 1/bfc00004/0",
                     bus.ireq_valid, bus.ireq_addr, bus.f_valid);
        end
    endtask

    task automatic test_branch_in_wait();
        bus.ireq_addr_ok = 1;
        step();
        clear_inputs();
        branch_valid = 1; branch_target = 32'h8000_0100;
        step();
        clear_inputs();
        checks++;
        if (bus.ireq_addr !== 32'h8000_0100 || bus.f_valid !== 1'b0) begin
            errors++;
            $display("FAIL branch_redirect got a=%h fv=%b want 80000100/0",
                     bus.ireq_addr, bus.f_valid);
        end
        bus.iresp_data_ok = 1; bus.iresp_data = 32'hdead_beef;
        step();
        clear_inputs();
        checks++;
        if (bus.f_valid !== 1'b0 || bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 32'h8000_0100)
        begin
            errors++;
            $display("FAIL branch_stale_drop got fv=%b v=%b a=%h want 0/1/80000100",
                     bus.f_valid, bus.ireq_valid, bus.ireq_addr);
        end
        bus.ireq_addr_ok = 1;
        step();
        clear_inputs();
        bus.iresp_data_ok = 1; bus.iresp_data = 32'h3c1d_0000;
        step();
        clear_inputs();
        checks++;
        if (bus.f_valid !== 1'b1 || bus.f_pc !== 32'h8000_0100 || bus.f_instr !== 32'h3c1d_0000)
        begin
            errors++;
            $display("FAIL branch_deliver got v=%b pc=%h ins=%h want 1/80000100/3c1d0000",
                     bus.f_valid, bus.f_pc, bus.f_instr);
        end
        bus.f_ready = 1;
        step();
        clear_inputs();
    endtask

    task automatic test_pending_redirect();
        dec_redirect_valid = 1; dec_redirect_pc = 32'h8000_0200;
        step();
        clear_inputs();
        checks++;
        if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 32'h8000_0104) begin
            errors++;
            $display("FAIL pend_stable1 got v=%b a=%h want 1/80000104",
                     bus.ireq_valid, bus.ireq_addr);
        end
        exc_valid = 1; exc_entrance = 32'hbfc0_0380;
        step();
        clear_inputs();
        step();
        checks++;
        if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 32'h8000_0104) begin
            errors++;
            $display("FAIL pend_stable2 got v=%b a=%h want 1/80000104",
                     bus.ireq_valid, bus.ireq_addr);
        end
        bus.ireq_addr_ok = 1;
        step();
        clear_inputs();
        checks++;
        if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 32'hbfc0_0380) begin
            errors++;
            $display("FAIL pend_applied got v=%b a=%h want 1/bfc00380",
                     bus.ireq_valid, bus.ireq_addr);
        end
        bus.iresp_data_ok = 1; bus.iresp_data = 32'hdead_beef;
        step();
        clear_inputs();
        checks++;
        if (bus.f_valid !== 1'b0) begin
            errors++; $display("FAIL pend_first_dropped got fv=%b want 0", bus.f_valid);
        end
        bus.ireq_addr_ok = 1;
        step();
        clear_inputs();
        bus.iresp_data_ok = 1; bus.iresp_data = 32'h1111_2222;
        step();
        clear_inputs();
        checks++;
        if (bus.f_valid !== 1'b1 || bus.f_pc !== 32'hbfc0_0380 || bus.f_instr !== 32'h1111_2222)
        begin
            errors++;
            $display("FAIL pend_deliver got v=%b pc=%h ins=%h want 1/bfc00380/11112222",
                     bus.f_valid, bus.f_pc, bus.f_instr);
        end
        bus.f_ready = 1;
        step();
        clear_inputs();
    endtask

    task automatic test_eret_priority();
        bus.ireq_addr_ok = 1;
        step();
        clear_inputs();
        eret_valid = 1; epc = 32'h8000_2000;
        branch_valid = 1; branch_target = 32'h8000_0100;
        step();
        clear_inputs();
        checks++;
        if (bus.ireq_addr !== 32'h8000_2000) begin
            errors++; $display("FAIL eret_priority got %h want 80002000", bus.ireq_addr);
        end
        bus.iresp_data_ok = 1; bus.iresp_data = 32'h0;
        step();
        clear_inputs();
        checks++;
        if (bus.f_valid !== 1'b0 || bus.ireq_valid !== 1'b1) begin
            errors++;
            $display("FAIL eret_stale got fv=%b v=%b want 0/1", bus.f_valid, bus.ireq_valid);
        end
    endtask

    task automatic test_hold_stall();
        bus.ireq_addr_ok = 1;
        step();
        clear_inputs();
        bus.iresp_data_ok = 1; bus.iresp_data = 32'haabb_ccdd;
        pred_taken = 1; pred_pc = 32'h8000_0040;
        step();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.f_valid !== 1'b1 || bus.f_pc !== 32'h8000_2000 ||
                bus.f_instr !== 32'haabb_ccdd || bus.ireq_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable[%0d] got fv=%b pc=%h ins=%h v=%b want 1/80002000/aabbccdd/0",
                         i, bus.f_valid, bus.f_pc, bus.f_instr, bus.ireq_valid);
            end
            step();
        end
        bus.f_ready = 1;
        step();
        clear_inputs();
        checks++;
        if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 32'h8000_0040 || bus.f_valid !== 1'b0)
        begin
            errors++;
            $display("FAIL hold_pred_next got v=%b a=%h fv=%b want 1/80000040/0",
                     bus.ireq_valid, bus.ireq_addr, bus.f_valid);
        end
    endtask

    task automatic test_reset_mid_wait();
        bus.ireq_addr_ok = 1;
        step();
        clear_inputs();
        branch_valid = 1; branch_target = 32'h8000_0300;
        step();
        clear_inputs();
        bus.ireq_addr_ok = 1;
        step();
        clear_inputs();
        checks++;
        if (bus.ireq_valid !== 1'b0) begin
            errors++; $display("FAIL midwait_ireq got %b want 0", bus.ireq_valid);
        end
        resetn = 0;
        step();
        resetn = 1;
        checks++;
        if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== ResetPc || bus.f_valid !== 1'b0) begin
            errors++;
            $display("FAIL midwait_reset got v=%b a=%h fv=%b want 1/%h/0",
                     bus.ireq_valid, bus.ireq_addr, bus.f_valid, ResetPc);
        end
        bus.ireq_addr_ok = 1;
        step();
        clear_inputs();
        bus.iresp_data_ok = 1; bus.iresp_data = 32'h0bad_f00d;
        step();
        clear_inputs();
        checks++;
        if (bus.f_valid !== 1'b1 || bus.f_pc !== ResetPc || bus.f_instr !== 32'h0bad_f00d) begin
            errors++;
            $display("FAIL midwait_drop_cleared got v=%b pc=%h ins=%h want 1/%h/0badf00d",
                     bus.f_valid, bus.f_pc, bus.f_instr, ResetPc);
        end
    endtask

    // Enters from HOLD at RESET_PC; refetch with f_ready in the same cycle kills the instruction.
    task automatic test_wrap_and_kill();
        refetch_valid = 1; refetch_pc = 32'hffff_fffc; bus.f_ready = 1;
        step();
        clear_inputs();
        checks++;
        if (bus.f_valid !== 1'b0 || bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 32'hffff_fffc)
        begin
            errors++;
            $display("FAIL kill_redirect got fv=%b v=%b a=%h want 0/1/fffffffc",
                     bus.f_valid, bus.ireq_valid, bus.ireq_addr);
        end
        bus.ireq_addr_ok = 1;
        step();
        clear_inputs();
        bus.iresp_data_ok = 1; bus.iresp_data = 32'h1234_5678;
        step();
        clear_inputs();
        bus.f_ready = 1;
        step();
        clear_inputs();
        checks++;
        if (bus.ireq_valid !== 1'b1 || bus.ireq_addr !== 32'h0000_0000) begin
            errors++;
            $display("FAIL wrap_pc got v=%b a=%h want 1/00000000", bus.ireq_valid, bus.ireq_addr);
        end
    endtask

    task automatic test_random(input int n_cycles);
        ent_t        mq[$];
        logic [31:0] bq[$];
        ent_t        e;
        logic [31:0] m_pc, m_fpc, m_finstr, m_pend_pc, tgt;
        logic        m_hold, m_pend, live, exp_req, fire_data, redir;
        int          m_pend_rk, rk, n_stale;
        logic        src_v[5];
        logic [31:0] src_t[5];

        clear_inputs();
        resetn = 0;
        step();
        resetn = 1;
        m_pc = ResetPc; m_hold = 0; m_pend = 0; m_pend_rk = 0; m_pend_pc = '0;
        m_fpc = '0; m_finstr = '0;

        for (int c = 0; c < n_cycles; c++) begin
            n_stale = 0;
            live    = 0;
            foreach (mq[i]) begin
                if (mq[i].live) live = 1;
                else n_stale++;
            end
            exp_req = !m_hold && !live && (n_stale < DropMax);

            checks++;
            if (bus.ireq_valid !== exp_req) begin
                errors++;
                $display("FAIL rand_ireq_valid c=%0d got %b want %b", c, bus.ireq_valid, exp_req);
            end
            checks++;
            if (bus.ireq_addr !== m_pc) begin
                errors++;
                $display("FAIL rand_ireq_addr c=%0d got %h want %h", c, bus.ireq_addr, m_pc);
            end
            checks++;
            if (bus.f_valid !== m_hold) begin
                errors++;
                $display("FAIL rand_f_valid c=%0d got %b want %b", c, bus.f_valid, m_hold);
            end
            if (m_hold) begin
                checks++;
                if (bus.f_pc !== m_fpc || bus.f_instr !== m_finstr) begin
                    errors++;
                    $display("FAIL rand_f_data c=%0d got %h/%h want %h/%h",
                             c, bus.f_pc, bus.f_instr, m_fpc, m_finstr);
                end
            end

            eret_valid         = ($urandom_range(0, 23) == 0);
            exc_valid          = ($urandom_range(0, 23) == 0);
            branch_valid       = ($urandom_range(0, 23) == 0);
            refetch_valid      = ($urandom_range(0, 23) == 0);
            dec_redirect_valid = ($urandom_range(0, 23) == 0);
            epc             = $urandom & 32'hffff_fffc;
            exc_entrance    = $urandom & 32'hffff_fffc;
            branch_target   = $urandom & 32'hffff_fffc;
            refetch_pc      = $urandom & 32'hffff_fffc;
            dec_redirect_pc = $urandom & 32'hffff_fffc;
            pred_taken      = ($urandom_range(0, 3) == 0);
            pred_pc         = $urandom & 32'hffff_fffc;
            bus.f_ready      = ($urandom_range(0, 4) < 3);
            bus.ireq_addr_ok = ($urandom_range(0, 1) == 0);
            fire_data = (bq.size() != 0) && ($urandom_range(0, 2) == 0);
            bus.iresp_data_ok = fire_data;
            bus.iresp_data    = fire_data ? mem_word(bq[0]) : $urandom;

            // Sources listed least to most urgent; the last asserted one wins.
            src_v = '{dec_redirect_valid, refetch_valid, branch_valid, exc_valid, eret_valid};
            src_t = '{dec_redirect_pc, refetch_pc, branch_target, exc_entrance, epc};
            rk  = 0;
            tgt = '0;
            for (int i = 0; i < 5; i++) begin
                if (src_v[i]) begin
                    rk  = i + 1;
                    tgt = src_t[i];
                end
            end
            redir = (rk != 0);

            if (m_hold) begin
                if (redir) begin
                    m_hold = 0;
                    m_pc   = tgt;
                end else if (bus.f_ready) begin
                    m_hold = 0;
                end
            end else if (live) begin
                if (fire_data) begin
                    e = mq.pop_front();
                    if (e.live) begin
                        if (redir) begin
                            m_pc = tgt;
                        end else begin
                            m_hold   = 1;
                            m_fpc    = e.addr;
                            m_finstr = mem_word(e.addr);
                            m_pc     = pred_taken ? pred_pc : m_pc + 32'd4;
                        end
                    end else if (redir) begin
                        foreach (mq[i]) mq[i].live = 0;
                        m_pc = tgt;
                    end
                end else if (redir) begin
                    foreach (mq[i]) mq[i].live = 0;
                    m_pc = tgt;
                end
            end else begin
                if (fire_data && mq.size() != 0) void'(mq.pop_front());
                if (exp_req && bus.ireq_addr_ok) begin
                    if (redir || m_pend) begin
                        mq.push_back('{addr: m_pc, live: 1'b0});
                        m_pc   = (redir && (!m_pend || rk >= m_pend_rk)) ? tgt : m_pend_pc;
                        m_pend = 0;
                    end else begin
                        mq.push_back('{addr: m_pc, live: 1'b1});
                    end
                end else if (redir && (!m_pend || rk >= m_pend_rk)) begin
                    m_pend    = 1;
                    m_pend_pc = tgt;
                    m_pend_rk = rk;
                end
            end

            if (fire_data) void'(bq.pop_front());
            if (bus.ireq_valid === 1'b1 && bus.ireq_addr_ok) bq.push_back(bus.ireq_addr);
            step();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        resetn = 0;
        test_reset();
        test_basic_fetch();
        test_branch_in_wait();
        test_pending_redirect();
        test_eret_priority();
        test_hold_stall();
        test_reset_mid_wait();
        test_wrap_and_kill();
        test_random(4000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
